fifo_write_arbiter: RTL and testbench

//  Shares the async FIFO write port among NUM_REQ requesters in the wclk domain.

---
 rtl/fifo_write_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Shares the write port of an async FIFO among NUM_REQ requesters in the
//   wclk domain. Round-robin arbitration with burst lock: the owner keeps the
//   port until its last beat is accepted, MAX_BURST beats are accepted, or it
//   drops its request. Re-arbitration always passes through one IDLE cycle.
//
//   Optional feature: define WARB_STALL_CNT_EN to add a saturating 16-bit
//   counter of cycles where the owner wants to write but the FIFO is full.
//
// Ports
//   wclk       in   write-domain clock, all logic on posedge
//   wrst_n     in   asynchronous active-low reset
//   req        in   per-requester write request (level)
//   req_data   in   per-requester data, slice i = [i*DATA_SIZE +: DATA_SIZE]
//   req_last   in   per-requester end-of-burst marker, valid with req
//   wfull      in   FIFO full flag (wclk domain)
//   gnt        out  one-hot registered grant
//   winc       out  FIFO write strobe
//   wdata      out  FIFO write data
//   busy       out  high while a grant is held
//   owner_id   out  index of the current or most recent owner
//   stall_clr  in   (WARB_STALL_CNT_EN) clears stall_cnt, wins over increment
//   stall_cnt  out  (WARB_STALL_CNT_EN) saturating stalled-cycle count
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int MAX_BURST = 4,
  localparam int OW = $clog2(NUM_REQ),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                           wclk,
  input  logic                           wrst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic                           wfull,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           winc,
  output logic [DATA_SIZE-1:0]           wdata,
  output logic                           busy,
  output logic [OW-1:0]                  owner_id
`ifdef WARB_STALL_CNT_EN
  ,
  input  logic                           stall_clr,
  output logic [15:0]                    stall_cnt
`endif
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t               state_r,      state_nxt_s;
  logic [NUM_REQ-1:0]   gnt_r,        gnt_nxt_s;
  logic [OW-1:0]        owner_r,      owner_nxt_s;
  logic [OW-1:0]        last_owner_r, last_owner_nxt_s;
  logic [BW-1:0]        beat_cnt_r,   beat_cnt_nxt_s;
  logic [OW-1:0]        pick_s;
  logic                 accept_s;
  logic                 release_s;

  // Round-robin search starting just after 'last' and wrapping NUM_REQ-1 -> 0;
  // 'last' itself is examined last so every requester is served within NUM_REQ grants.
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [OW-1:0]      last);
    logic [OW-1:0] idx;
    logic [OW-1:0] sel;
    logic          found;
    idx   = last;
    sel   = {OW{1'b0}};
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (idx == OW'(NUM_REQ - 1)) begin
        idx = {OW{1'b0}};
      end else begin
        idx = idx + {{(OW-1){1'b0}}, 1'b1};
      end
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  // Handshake and release conditions of the current owner.
  always_comb begin
    pick_s    = rr_pick(req, last_owner_r);
    accept_s  = (state_r == BURST) & req[owner_r] & ~wfull;
    // A beat flagged last (or the MAX_BURST-th beat) only releases once accepted;
    // a dropped request releases regardless of wfull.
    release_s = ~req[owner_r] |
                (accept_s & (req_last[owner_r] | (beat_cnt_r == BW'(MAX_BURST - 1))));
  end

  // Next-state logic: arbitration in IDLE, burst bookkeeping in BURST.
  always_comb begin
    state_nxt_s      = state_r;
    gnt_nxt_s        = gnt_r;
    owner_nxt_s      = owner_r;
    last_owner_nxt_s = last_owner_r;
    beat_cnt_nxt_s   = beat_cnt_r;
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_nxt_s    = BURST;
          gnt_nxt_s      = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
          owner_nxt_s    = pick_s;
          beat_cnt_nxt_s = {BW{1'b0}};
        end else begin
          state_nxt_s    = IDLE;
        end
      end
      BURST: begin
        if (release_s) begin
          state_nxt_s      = IDLE;
          gnt_nxt_s        = {NUM_REQ{1'b0}};
          last_owner_nxt_s = owner_r;
        end else begin
          beat_cnt_nxt_s   = beat_cnt_r + BW'(accept_s);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        gnt_nxt_s   = {NUM_REQ{1'b0}};
      end
    endcase
  end

  // State register: reset leaves requester 0 as the first winner.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_r      <= IDLE;
      gnt_r        <= {NUM_REQ{1'b0}};
      owner_r      <= {OW{1'b0}};
      last_owner_r <= OW'(NUM_REQ - 1);
      beat_cnt_r   <= {BW{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      gnt_r        <= gnt_nxt_s;
      owner_r      <= owner_nxt_s;
      last_owner_r <= last_owner_nxt_s;
      beat_cnt_r   <= beat_cnt_nxt_s;
    end
  end

  // Outputs: winc/wdata follow the accept combinationally so a beat is written
  // in the same cycle the requester sees it consumed.
  always_comb begin
    gnt      = gnt_r;
    busy     = (state_r == BURST);
    owner_id = owner_r;
    winc     = accept_s;
    if (accept_s) begin
      wdata = req_data[owner_r*DATA_SIZE +: DATA_SIZE];
    end else begin
      wdata = {DATA_SIZE{1'b0}};
    end
  end

`ifdef WARB_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Stalled-cycle counter: clear wins, then saturating increment.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stall_cnt_r <= 16'h0000;
    end else if (stall_clr) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == BURST) && req[owner_r] && wfull && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter (NUM_REQ=4, DATA_SIZE=8, MAX_BURST=4).
// Bench-side requesters hold beats until gnt&req&~wfull; expected writes and
// expected burst lengths are queued per test and checked as the DUT produces them.
module tb_fifo_write_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            wclk;
  logic            wrst_n;
  logic [NR-1:0]   req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic            wfull;
  logic [NR-1:0]   gnt;
  logic            winc;
  logic [DW-1:0]   wdata;
  logic            busy;
  logic [1:0]      owner_id;
`ifdef WARB_STALL_CNT_EN
  logic            stall_clr;
  logic [15:0]     stall_cnt;
`endif

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DW), .MAX_BURST(MB)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data),
    .req_last(req_last), .wfull(wfull), .gnt(gnt), .winc(winc),
    .wdata(wdata), .busy(busy), .owner_id(owner_id)
`ifdef WARB_STALL_CNT_EN
    , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] exp_q[$];   // {id, data}
  int          len_q[$];   // expected beats per grant
  bit          sb_on   = 1'b1;
  bit          gap_en  = 1'b0;
  bit          seen_burst = 1'b0;

  int taken [NR];          // beats consumed per requester (monitor only)
  int base  [NR];
  int total [NR];
  bit lmode [NR];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < NR; i++) begin
      int c;
      c = taken[i] - base[i];
      req[i]              = (total[i] - c) > 0;
      req_data[i*DW +: DW] = {4'(i), 4'(c)};
      req_last[i]         = lmode[i] && ((total[i] - c) == 1);
    end
  endtask

  task automatic load(input int i, input int beats, input bit lst);
    base[i]  = taken[i];
    total[i] = beats;
    lmode[i] = lst;
    drive_req();
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
    drive_req();
  endtask

  task automatic push_exp(input int id, input int first, input int n);
    for (int b = 0; b < n; b++) exp_q.push_back({4'(id), 4'(id), 4'(first + b)});
  endtask

  task automatic wait_done(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (exp_q.size() == 0 && len_q.size() == 0) break;
      tick();
    end
    check("all_done", 32'(exp_q.size() + len_q.size()), 32'd0);
    exp_q.delete();
    len_q.delete();
  endtask

  task automatic wait_beats(input int i, input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if ((taken[i] - base[i]) >= n) break;
      tick();
    end
    check("beats_reached", 32'(taken[i] - base[i]), 32'(n));
  endtask

  // Monitor: requester-side handshake, write scoreboard and burst-length scoreboard.
  initial begin
    logic [NR-1:0] acc;
    logic [11:0]   e;
    bit            prev_busy;
    int            burst_beats;
    int            idle_run;
    prev_busy = 1'b0; burst_beats = 0; idle_run = 0;
    for (int i = 0; i < NR; i++) taken[i] = 0;
    forever begin
      @(negedge wclk);
      if (!wrst_n) begin
        prev_busy = 1'b0; burst_beats = 0;
      end else begin
        acc = gnt & req & {NR{~wfull}};
        check("winc", 32'(winc), 32'(|acc));
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        for (int i = 0; i < NR; i++) begin
          if (acc[i]) begin
            taken[i]++;
            burst_beats++;
            if (sb_on) begin
              if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(i), 32'hFFFF);
              end else begin
                e = exp_q.pop_front();
                check("wr_owner", 32'(i), 32'(e[11:8]));
                check("wdata", 32'(wdata), 32'(e[7:0]));
              end
            end
          end
        end
        if (busy && !prev_busy) begin
          if (gap_en && seen_burst) check("idle_gap", 32'(idle_run), 32'd1);
          seen_burst = 1'b1;
          idle_run = 0;
        end else if (!busy) begin
          idle_run++;
        end
        if (prev_busy && !busy) begin
          if (sb_on) begin
            if (len_q.size() == 0) check("unexpected_release", 32'(burst_beats), 32'hFFFF);
            else check("burst_len", 32'(burst_beats), 32'(len_q.pop_front()));
          end
          burst_beats = 0;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wrst_n = 1'b0; wfull = 1'b0; req = '0; req_data = '0; req_last = '0;
`ifdef WARB_STALL_CNT_EN
    stall_clr = 1'b0;
`endif
    for (int i = 0; i < NR; i++) begin base[i] = 0; total[i] = 0; lmode[i] = 1'b0; end
    #3;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_winc", 32'(winc), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_owner", 32'(owner_id), 32'd0);
    tick(); tick();
    wrst_n = 1'b1;

    // Test 1: single requester, req_last on beat 3
    tick();
    load(0, 3, 1'b1);
    push_exp(0, 0, 3); len_q.push_back(3);
    @(negedge wclk);
    check("t1_gnt_before", 32'(gnt), 32'd0);
    tick();
    @(negedge wclk);
    check("t1_gnt", 32'(gnt), 32'b0001);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_owner", 32'(owner_id), 32'd0);
    wait_done(40);

    // Fresh reset so requester 0 wins first again
    wrst_n = 1'b0; tick(); wrst_n = 1'b1;

    // Test 2: all requesting, no last -> 0,1,2,3,0 with 4 beats each
    gap_en = 1'b1; seen_burst = 1'b0;
    load(0, 8, 1'b0); load(1, 4, 1'b0); load(2, 4, 1'b0); load(3, 4, 1'b0);
    push_exp(0, 0, 4); push_exp(1, 0, 4); push_exp(2, 0, 4); push_exp(3, 0, 4); push_exp(0, 4, 4);
    repeat (5) len_q.push_back(4);
    wait_done(100);

    // Test 3: owner 2 stalls for 5 cycles after 2 beats; burst still ends at 4
    seen_burst = 1'b0;
    load(2, 6, 1'b0);
    push_exp(2, 0, 6); len_q.push_back(4); len_q.push_back(2);
    wait_beats(2, 2, 20);
    wfull = 1'b1;
    repeat (5) begin
      @(negedge wclk);
      check("t3_gnt_held", 32'(gnt), 32'b0100);
      check("t3_busy_held", 32'(busy), 32'd1);
      tick();
    end
    wfull = 1'b0;
    wait_done(40);
    gap_en = 1'b0;

    // Test 4: owner 1 drops req after 2 beats, next grant goes to 2
    load(1, 2, 1'b0); load(2, 1, 1'b1);
    push_exp(1, 0, 2); push_exp(2, 0, 1);
    len_q.push_back(2); len_q.push_back(1);
    wait_done(40);

    // Test 5: reset mid-burst
    sb_on = 1'b0;
    for (int i = 0; i < NR; i++) load(i, 8, 1'b0);
    tick();
    @(negedge wclk);
    check("t5_gnt_owner3", 32'(gnt), 32'b1000);
    tick(); tick();
    #2 wrst_n = 1'b0;
    #1;
    check("t5_rst_gnt", 32'(gnt), 32'd0);
    check("t5_rst_winc", 32'(winc), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < NR; i++) load(i, 1, 1'b1);
    push_exp(0, 0, 1); push_exp(1, 0, 1); push_exp(2, 0, 1); push_exp(3, 0, 1);
    repeat (4) len_q.push_back(1);
    sb_on = 1'b1;
    tick(); tick();
    wrst_n = 1'b1;
    @(negedge wclk);
    check("t5_idle_after_rst", 32'(gnt), 32'd0);
    tick();
    @(negedge wclk);
    check("t5_first_gnt", 32'(gnt), 32'b0001);
    wait_done(40);

`ifdef WARB_STALL_CNT_EN
    // Test 6: 10 stalled cycles, then clear
    check("t6_cnt_start", 32'(stall_cnt), 32'd0);
    wfull = 1'b1;
    load(0, 1, 1'b1);
    push_exp(0, 0, 1); len_q.push_back(1);
    tick();
    repeat (10) tick();
    @(negedge wclk);
    check("t6_cnt10", 32'(stall_cnt), 32'd10);
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    @(negedge wclk);
    check("t6_cnt_clr", 32'(stall_cnt), 32'd0);
    wfull = 1'b0;
    wait_done(20);
`endif

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
